// File: rtl/hms_alarm_clock.sv
// hms_alarm_clock
//   Binary hours/minutes/seconds clock with one alarm and three debounced,
//   active-low push buttons (mode, position, increment).
//
// Ports
//   clk, rst_n                    single clock, asynchronous active-low reset
//   i_sw_mode/i_sw_pos/i_sw_inc   raw active-low buttons (asynchronous to clk)
//   o_sec/o_min/o_hour            current time, binary
//   o_alarm_min/o_alarm_hour      alarm time, binary
//   o_mode                        0=CLOCK 1=SETUP 2=ALARM
//   o_position                    0=SEC 1=MIN 2=HOUR (field selected for edits)
//   o_alarm_en / o_alarm          alarm armed / alarm ringing
//   o_tick                        one-cycle 1 Hz pulse
module hms_alarm_clock #(
  parameter int CLK_HZ    = 50000000,
  parameter int DEB_HZ    = 100,
  parameter int DEB_CNT   = 3,
  parameter int HOUR_MAX  = 23,
  parameter int ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [5:0] o_alarm_min,
  output logic [4:0] o_alarm_hour,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_alarm_en,
  output logic       o_alarm,
  output logic       o_tick
);

  localparam int DEB_DIV = CLK_HZ / DEB_HZ;
  localparam int PW      = $clog2(CLK_HZ + 1);
  localparam int DVW     = $clog2(DEB_DIV + 1);
  localparam int DCW     = $clog2(DEB_CNT + 1);
  localparam int AW      = $clog2(ALARM_SEC + 1);
  localparam logic [4:0] HOUR_TOP = 5'(HOUR_MAX);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] top);
    return (v >= top) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK: return MODE_SETUP;
      MODE_SETUP: return MODE_ALARM;
      default:    return MODE_CLOCK;
    endcase
  endfunction

  function automatic pos_e next_pos(input pos_e p);
    case (p)
      POS_SEC: return POS_MIN;
      POS_MIN: return POS_HOUR;
      default: return POS_SEC;
    endcase
  endfunction

  // Button index: 0 = mode, 1 = pos, 2 = inc
  logic [2:0]          sw_raw;
  logic [2:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]          level_q, level_d, armed_q, armed_d, press_q, press_d;
  logic [2:0][DCW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DVW-1:0]      deb_div_q, deb_div_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [5:0]          sec_q, sec_d, min_q, min_d, alarm_min_q, alarm_min_d;
  logic [4:0]          hour_q, hour_d, alarm_hour_q, alarm_hour_d;
  mode_e               mode_q, mode_d;
  pos_e                pos_q, pos_d;
  logic                alarm_en_q, alarm_en_d, alarm_q, alarm_d;
  logic [AW-1:0]       alarm_cnt_q, alarm_cnt_d;

  logic sample_en, ev_mode, ev_pos, ev_inc, any_press, alarm_match;

  assign sw_raw = {i_sw_inc, i_sw_pos, i_sw_mode};

  always_comb begin
    sync1_d      = sw_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    armed_d      = armed_q;
    press_d      = '0;
    deb_cnt_d    = deb_cnt_q;
    deb_div_d    = deb_div_q;
    presc_d      = presc_q;
    tick_d       = 1'b0;
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;
    mode_d       = mode_q;
    pos_d        = pos_q;
    alarm_en_d   = alarm_en_q;
    alarm_d      = alarm_q;
    alarm_cnt_d  = alarm_cnt_q;
    alarm_match  = 1'b0;

    // ---- debounce: sample strobe, per-button acceptance counter ----
    sample_en = (deb_div_q == DVW'(DEB_DIV - 1));
    deb_div_d = sample_en ? '0 : deb_div_q + DVW'(1);
    for (int i = 0; i < 3; i++) begin
      if (sample_en) begin
        // A button must be seen released before its falling edge counts, so a
        // button held through reset cannot produce a press once reset lifts.
        armed_d[i] = armed_q[i] | sync2_q[i];
        if (sync2_q[i] == level_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == DCW'(DEB_CNT - 1)) begin
          deb_cnt_d[i] = '0;
          level_d[i]   = sync2_q[i];
          press_d[i]   = armed_q[i] & ~sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
        end
      end
    end

    // ---- command decode from registered press pulses ----
    ev_mode   = press_q[0];
    ev_pos    = press_q[1];
    ev_inc    = press_q[2];
    any_press = |press_q;

    // A press while ringing only silences the alarm.
    if (!(alarm_q && any_press)) begin
      if (ev_mode) begin
        mode_d = next_mode(mode_q);
        pos_d  = POS_SEC;
      end else if (ev_pos) begin
        pos_d = next_pos(pos_q);
      end else if (ev_inc) begin
        case (mode_q)
          MODE_CLOCK: alarm_en_d = ~alarm_en_q;
          MODE_SETUP: begin
            case (pos_q)
              POS_SEC:  sec_d  = inc_wrap6(sec_q, 6'd59);
              POS_MIN:  min_d  = inc_wrap6(min_q, 6'd59);
              default:  hour_d = inc_wrap5(hour_q, HOUR_TOP);
            endcase
          end
          default: begin
            if (pos_q == POS_MIN)       alarm_min_d  = inc_wrap6(alarm_min_q, 6'd59);
            else if (pos_q == POS_HOUR) alarm_hour_d = inc_wrap5(alarm_hour_q, HOUR_TOP);
          end
        endcase
      end
    end

    // ---- timekeeping: full carry chain resolves in one cycle ----
    if (tick_q && mode_q != MODE_SETUP) begin
      sec_d = inc_wrap6(sec_q, 6'd59);
      if (sec_q == 6'd59) begin
        min_d = inc_wrap6(min_q, 6'd59);
        if (min_q == 6'd59) hour_d = inc_wrap5(hour_q, HOUR_TOP);
      end
      alarm_match = alarm_en_d && (sec_d == 6'd0) && (min_d == alarm_min_q) &&
                    (hour_d == alarm_hour_q);
    end

    // ---- alarm ring / timeout ----
    if (alarm_q) begin
      if (any_press) alarm_d = 1'b0;
      if (tick_q) begin
        if (alarm_cnt_q == AW'(ALARM_SEC - 1)) alarm_d = 1'b0;
        else                                   alarm_cnt_d = alarm_cnt_q + AW'(1);
      end
      if (!alarm_en_d) alarm_d = 1'b0;
    end else if (alarm_match) begin
      alarm_d     = 1'b1;
      alarm_cnt_d = '0;
    end

    // ---- prescaler: frozen at zero while time is being edited ----
    if (mode_q == MODE_SETUP) presc_d = '0;
    else if (presc_q == PW'(CLK_HZ - 1)) presc_d = '0;
    else presc_d = presc_q + PW'(1);
    // Registered tick lines up with the cycle in which presc_q == CLK_HZ-1.
    tick_d = (presc_d == PW'(CLK_HZ - 1)) && (mode_d != MODE_SETUP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '1;
      armed_q      <= '0;
      press_q      <= '0;
      deb_cnt_q    <= '0;
      deb_div_q    <= '0;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      sec_q        <= '0;
      min_q        <= '0;
      hour_q       <= '0;
      alarm_min_q  <= '0;
      alarm_hour_q <= '0;
      mode_q       <= MODE_CLOCK;
      pos_q        <= POS_SEC;
      alarm_en_q   <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_cnt_q  <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      armed_q      <= armed_d;
      press_q      <= press_d;
      deb_cnt_q    <= deb_cnt_d;
      deb_div_q    <= deb_div_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      alarm_en_q   <= alarm_en_d;
      alarm_q      <= alarm_d;
      alarm_cnt_q  <= alarm_cnt_d;
    end
  end

  assign o_sec        = sec_q;
  assign o_min        = min_q;
  assign o_hour       = hour_q;
  assign o_alarm_min  = alarm_min_q;
  assign o_alarm_hour = alarm_hour_q;
  assign o_mode       = mode_q;
  assign o_position   = pos_q;
  assign o_alarm_en   = alarm_en_q;
  assign o_alarm      = alarm_q;
  assign o_tick       = tick_q;

endmodule

// File: tb/tb_hms_alarm_clock.sv
// Directed testbench for hms_alarm_clock with a small clock (CLK_HZ=20,
// DEB_HZ=10, DEB_CNT=2, ALARM_SEC=3). Time expectations come from a tick
// counting model: expected time = reference time + ticks seen since reference.
module tb_hms_alarm_clock;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_mode = 1'b1, sw_pos = 1'b1, sw_inc = 1'b1;
  logic [5:0] o_sec, o_min, o_alarm_min;
  logic [4:0] o_hour, o_alarm_hour;
  logic [1:0] o_mode, o_position;
  logic       o_alarm_en, o_alarm, o_tick;

  int vectors = 0;
  int errors  = 0;
  int tick_seen = 0;
  int base_total = 0;
  int k_ref = 0;
  logic [5:0] snap_sec, snap_min;
  logic [4:0] snap_hour;
  logic       snap_alarm;

  hms_alarm_clock #(
    .CLK_HZ(20), .DEB_HZ(10), .DEB_CNT(2), .HOUR_MAX(23), .ALARM_SEC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sw_mode(sw_mode), .i_sw_pos(sw_pos), .i_sw_inc(sw_inc),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_alarm_min(o_alarm_min), .o_alarm_hour(o_alarm_hour),
    .o_mode(o_mode), .o_position(o_position),
    .o_alarm_en(o_alarm_en), .o_alarm(o_alarm), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  // Tick monitor: counts ticks and captures the pre-update state.
  always @(negedge clk) begin
    if (rst_n && o_tick === 1'b1) begin
      tick_seen  <= tick_seen + 1;
      snap_sec   <= o_sec;
      snap_min   <= o_min;
      snap_hour  <= o_hour;
      snap_alarm <= o_alarm;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic int mdl_total();
    return base_total + (tick_seen - k_ref);
  endfunction

  task automatic set_ref(input int tot);
    base_total = tot;
    k_ref      = tick_seen;
  endtask

  task automatic press(input bit m, input bit p, input bit i, input int low_cyc);
    @(negedge clk);
    if (m) sw_mode = 1'b0;
    if (p) sw_pos  = 1'b0;
    if (i) sw_inc  = 1'b0;
    repeat (low_cyc) @(negedge clk);
    sw_mode = 1'b1; sw_pos = 1'b1; sw_inc = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_ticks(input int target);
    int guard = 0;
    while (tick_seen < target && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    vectors++;
    if (tick_seen < target) begin
      errors++;
      $display("FAIL tick_wait got %0d ticks required %0d", tick_seen, target);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_sec, o_min, o_hour, o_alarm_min, o_alarm_hour, o_mode, o_position,
         o_alarm_en, o_alarm, o_tick} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state got %h required 0", {o_sec, o_min, o_hour, o_alarm_min,
               o_alarm_hour, o_mode, o_position, o_alarm_en, o_alarm, o_tick});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    set_ref(0);
  endtask

  task automatic test_setup_wrap();
    int tot, es, em, t_s;
    press(1, 0, 0, 8);
    vectors++; if (o_mode !== 2'd1) begin errors++; $display("FAIL setup_mode got %0d required 1", o_mode); end
    vectors++; if (o_position !== 2'd0) begin errors++; $display("FAIL setup_pos got %0d required 0", o_position); end
    tot = mdl_total(); es = tot % 60; em = (tot / 60) % 60; t_s = tick_seen;
    repeat (59 - es) press(0, 0, 1, 8);
    vectors++; if (o_sec !== 6'd59) begin errors++; $display("FAIL setup_sec59 got %0d required 59", o_sec); end
    press(0, 0, 1, 8);
    vectors++; if (o_sec !== 6'd0) begin errors++; $display("FAIL setup_sec_wrap got %0d required 0", o_sec); end
    vectors++; if (o_min !== 6'(em)) begin errors++; $display("FAIL setup_no_carry got %0d required %0d", o_min, em); end
    vectors++; if (tick_seen !== t_s) begin errors++; $display("FAIL setup_no_tick got %0d required %0d", tick_seen, t_s); end
    set_ref(em * 60);
  endtask

  task automatic test_rollover();
    int tot, em, eh, t0;
    tot = mdl_total(); em = (tot / 60) % 60; eh = (tot / 3600) % 24;
    repeat (58) press(0, 0, 1, 8);
    press(0, 1, 0, 8);
    repeat (59 - em) press(0, 0, 1, 8);
    press(0, 1, 0, 8);
    repeat (23 - eh) press(0, 0, 1, 8);
    vectors++;
    if ({o_hour, o_min, o_sec} !== {5'd23, 6'd59, 6'd58}) begin
      errors++; $display("FAIL roll_setup got %0d:%0d:%0d required 23:59:58", o_hour, o_min, o_sec);
    end
    vectors++; if (o_position !== 2'd2) begin errors++; $display("FAIL roll_pos got %0d required 2", o_position); end
    t0 = tick_seen;
    press(1, 0, 0, 8);
    vectors++; if ({o_mode, o_position} !== {2'd2, 2'd0}) begin
      errors++; $display("FAIL roll_alarm_mode got %0d/%0d required 2/0", o_mode, o_position); end
    press(1, 0, 0, 8);
    vectors++; if (o_mode !== 2'd0) begin errors++; $display("FAIL roll_clock_mode got %0d required 0", o_mode); end
    wait_ticks(t0 + 2);
    vectors++;
    if ({snap_hour, snap_min, snap_sec} !== {5'd23, 6'd59, 6'd59}) begin
      errors++; $display("FAIL roll_before got %0d:%0d:%0d required 23:59:59", snap_hour, snap_min, snap_sec);
    end
    vectors++;
    if ({o_hour, o_min, o_sec} !== 17'd0) begin
      errors++; $display("FAIL roll_after got %0d:%0d:%0d required 0:0:0", o_hour, o_min, o_sec);
    end
    set_ref(0);
  endtask

  task automatic test_alarm();
    int tot, es, t1;
    press(1, 0, 0, 8);
    press(1, 0, 0, 8);
    press(0, 1, 0, 8);
    press(0, 0, 1, 8);
    vectors++; if ({o_alarm_hour, o_alarm_min} !== {5'd0, 6'd1}) begin
      errors++; $display("FAIL alarm_set got %0d:%0d required 0:1", o_alarm_hour, o_alarm_min); end
    press(1, 0, 0, 8);
    press(0, 0, 1, 8);
    vectors++; if (o_alarm_en !== 1'b1) begin errors++; $display("FAIL alarm_enable got %0d required 1", o_alarm_en); end
    press(1, 0, 0, 8);
    tot = mdl_total(); es = tot % 60;
    repeat (59 - es) press(0, 0, 1, 8);
    vectors++; if ({o_hour, o_min, o_sec} !== {5'd0, 6'd0, 6'd59}) begin
      errors++; $display("FAIL alarm_time got %0d:%0d:%0d required 0:0:59", o_hour, o_min, o_sec); end
    set_ref(59);
    t1 = tick_seen;
    press(1, 0, 0, 8);
    wait_ticks(t1 + 1);
    vectors++; if (snap_alarm !== 1'b0) begin errors++; $display("FAIL alarm_early got %0d required 0", snap_alarm); end
    vectors++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL alarm_ring got %0d required 1", o_alarm); end
    vectors++; if ({o_min, o_sec} !== {6'd1, 6'd0}) begin
      errors++; $display("FAIL alarm_ring_time got %0d:%0d required 1:0", o_min, o_sec); end
    set_ref(60);
    press(0, 1, 0, 8);
    vectors++; if (o_alarm !== 1'b0) begin errors++; $display("FAIL alarm_ack got %0d required 0", o_alarm); end
    vectors++; if ({o_mode, o_position} !== {2'd2, 2'd0}) begin
      errors++; $display("FAIL alarm_ack_noeffect got %0d/%0d required 2/0", o_mode, o_position); end
  endtask

  task automatic test_timeout();
    int tot, es, t2;
    press(0, 1, 0, 8);
    press(0, 0, 1, 8);
    vectors++; if (o_alarm_min !== 6'd2) begin errors++; $display("FAIL tmo_alarm_min got %0d required 2", o_alarm_min); end
    press(1, 0, 0, 8);
    press(1, 0, 0, 8);
    tot = mdl_total(); es = tot % 60;
    repeat (59 - es) press(0, 0, 1, 8);
    vectors++; if ({o_min, o_sec} !== {6'd1, 6'd59}) begin
      errors++; $display("FAIL tmo_time got %0d:%0d required 1:59", o_min, o_sec); end
    set_ref(119);
    t2 = tick_seen;
    press(1, 0, 0, 8);
    wait_ticks(t2 + 1);
    vectors++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL tmo_ring got %0d required 1", o_alarm); end
    wait_ticks(t2 + 3);
    vectors++; if (o_alarm !== 1'b1) begin errors++; $display("FAIL tmo_hold got %0d required 1", o_alarm); end
    wait_ticks(t2 + 4);
    vectors++; if (snap_alarm !== 1'b1) begin errors++; $display("FAIL tmo_pre got %0d required 1", snap_alarm); end
    vectors++; if (o_alarm !== 1'b0) begin errors++; $display("FAIL tmo_clear got %0d required 0", o_alarm); end
    set_ref(123);
  endtask

  task automatic test_contention();
    int tot;
    press(1, 0, 0, 8);
    vectors++; if (o_mode !== 2'd0) begin errors++; $display("FAIL cont_clock got %0d required 0", o_mode); end
    press(1, 0, 1, 8);
    vectors++; if (o_mode !== 2'd1) begin errors++; $display("FAIL cont_mode got %0d required 1", o_mode); end
    vectors++; if (o_alarm_en !== 1'b1) begin errors++; $display("FAIL cont_inc_dropped got %0d required 1", o_alarm_en); end
    tot = mdl_total();
    press(0, 1, 1, 8);
    vectors++; if (o_position !== 2'd1) begin errors++; $display("FAIL cont_pos got %0d required 1", o_position); end
    vectors++; if ({o_min, o_sec} !== {6'((tot / 60) % 60), 6'(tot % 60)}) begin
      errors++; $display("FAIL cont_pos_inc got %0d:%0d required %0d:%0d", o_min, o_sec, (tot / 60) % 60, tot % 60); end
  endtask

  task automatic test_debounce();
    press(0, 1, 0, 2);
    vectors++; if (o_position !== 2'd1) begin errors++; $display("FAIL deb_glitch got %0d required 1", o_position); end
    press(0, 1, 0, 10);
    vectors++; if (o_position !== 2'd2) begin errors++; $display("FAIL deb_held got %0d required 2", o_position); end
  endtask

  task automatic test_async_reset();
    int eh;
    eh = (mdl_total() / 3600) % 24;
    repeat (7 - eh) press(0, 0, 1, 8);
    vectors++; if ({o_mode, o_hour} !== {2'd1, 5'd7}) begin
      errors++; $display("FAIL ares_setup got mode %0d hour %0d required 1/7", o_mode, o_hour); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_sec, o_min, o_hour, o_alarm_min, o_alarm_hour, o_mode, o_position,
         o_alarm_en, o_alarm, o_tick} !== 35'd0) begin
      errors++;
      $display("FAIL ares_immediate got %h required 0", {o_sec, o_min, o_hour, o_alarm_min,
               o_alarm_hour, o_mode, o_position, o_alarm_en, o_alarm, o_tick});
    end
    sw_inc = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    sw_inc = 1'b1;
    repeat (12) @(negedge clk);
    vectors++; if ({o_mode, o_alarm_en, o_alarm} !== 4'b0000) begin
      errors++; $display("FAIL ares_held_press got %b required 0000", {o_mode, o_alarm_en, o_alarm}); end
  endtask

  initial begin
    test_reset();
    test_setup_wrap();
    test_rollover();
    test_alarm();
    test_timeout();
    test_contention();
    test_debounce();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
